// File: rtl/nios_system_tec2_cpu_cpu_ocimem_ctrl_if.sv
// nios_system_tec2_cpu_cpu_ocimem_ctrl_if: JTAG debug-slave strobes/data and CPU Avalon-MM slave signals
// for the OCI debug RAM controller; slave = controller side, master = requester side.
interface nios_system_tec2_cpu_cpu_ocimem_ctrl_if #(parameter int ADDR_W = 8);
   logic [37:0]       jdo;
   logic              take_action_ocimem_a;
   logic              take_no_action_ocimem_a;
   logic              take_action_ocimem_b;
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic [31:0]       readdata;
   logic              waitrequest;
   logic [31:0]       MonDReg;
   logic              monitor_ready;
   logic              monitor_error;
   modport slave (
      input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
      input  address, read, write, writedata, byteenable,
      output readdata, waitrequest, MonDReg, monitor_ready, monitor_error
   );
   modport master (
      output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
      output address, read, write, writedata, byteenable,
      input  readdata, waitrequest, MonDReg, monitor_ready, monitor_error
   );
endinterface

// File: rtl/nios_system_tec2_cpu_cpu_ocimem_ctrl.sv
// nios_system_tec2_cpu_cpu_ocimem_ctrl: OCI debug RAM shared by JTAG (priority) and a CPU Avalon-MM port.
// Define OCIMEM_AUTOINC_EN to auto-increment MonAReg on JTAG writes and read-next.
module nios_system_tec2_cpu_cpu_ocimem_ctrl #(parameter int ADDR_W = 8) (
   input logic clk,
   input logic reset_n,
   nios_system_tec2_cpu_cpu_ocimem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, JTAG_RD, CPU_RD} state_t;
   state_t            r_state, w_state_nxt;
   logic [ADDR_W:0]   r_mon_a, w_a_fsm, w_a_next, w_jdo_a;
   logic [31:0]       r_mon_d, r_readdata, r_q, w_wdata;
   logic              r_ready, r_error, r_rd_pend, r_wr_pend, r_oor;
   logic              w_we, w_re, w_jwr, w_jrd, w_oor, w_discard, w_done, w_unused;
   logic [ADDR_W-1:0] w_addr;
   logic [3:0]        w_be;
   logic [31:0]       r_mem [2**ADDR_W];

   assign w_jdo_a   = bus.jdo[26 +: ADDR_W+1];
   assign w_oor     = r_mon_a[ADDR_W];
   assign w_unused  = ^{bus.jdo[37:35], bus.jdo[2:0]};
   // a newer JTAG read request makes the in-flight capture stale
   assign w_discard = r_rd_pend | bus.take_action_ocimem_a | bus.take_no_action_ocimem_a;

`ifdef OCIMEM_AUTOINC_EN
   assign w_a_fsm  = r_mon_a + {{ADDR_W{1'b0}}, w_jwr};
   assign w_a_next = w_a_fsm + {{ADDR_W{1'b0}}, 1'b1};
`else
   assign w_a_fsm  = r_mon_a;
   assign w_a_next = r_mon_a;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_re        = 1'b0;
      w_jwr       = 1'b0;
      w_jrd       = 1'b0;
      w_done      = 1'b0;
      w_addr      = bus.address;
      w_wdata     = bus.writedata;
      w_be        = bus.byteenable;
      case (r_state)
         IDLE:
            if (r_wr_pend) begin
               w_jwr   = 1'b1;
               w_we    = ~w_oor;
               w_addr  = r_mon_a[ADDR_W-1:0];
               w_wdata = r_mon_d;
               w_be    = 4'hf;
            end else if (r_rd_pend) begin
               w_jrd       = 1'b1;
               w_re        = ~w_oor;
               w_addr      = r_mon_a[ADDR_W-1:0];
               w_state_nxt = JTAG_RD;
            end else if (bus.write) begin
               w_we   = 1'b1;
               w_done = 1'b1;
            end else if (bus.read) begin
               w_re        = 1'b1;
               w_state_nxt = CPU_RD;
            end
         JTAG_RD: w_state_nxt = IDLE;
         CPU_RD: begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_we)
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
      if (w_re) r_q <= r_mem[w_addr];
   end

   // strobes are applied last so a new JTAG command overrides FSM bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_mon_a    <= '0;
         r_mon_d    <= '0;
         r_readdata <= '0;
         r_ready    <= 1'b0;
         r_error    <= 1'b0;
         r_rd_pend  <= 1'b0;
         r_wr_pend  <= 1'b0;
         r_oor      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mon_a <= w_a_fsm;
         if (w_jwr) r_wr_pend <= 1'b0;
         if (w_jrd) begin
            r_rd_pend <= 1'b0;
            r_oor     <= w_oor;
         end
         if ((w_jwr | w_jrd) & w_oor) r_error <= 1'b1;
         if (r_state == JTAG_RD && !w_discard) begin
            r_ready <= 1'b1;
            if (!r_oor) r_mon_d <= r_q;
         end
         if (r_state == CPU_RD) r_readdata <= r_q;
         if (bus.take_action_ocimem_a) begin
            r_mon_a   <= w_jdo_a;
            r_ready   <= 1'b0;
            r_error   <= 1'b0;
            r_rd_pend <= bus.jdo[17];
         end
         if (bus.take_no_action_ocimem_a) begin
            r_mon_a   <= w_a_next;
            r_ready   <= 1'b0;
            r_rd_pend <= 1'b1;
         end
         if (bus.take_action_ocimem_b) begin
            r_mon_d   <= bus.jdo[34:3];
            r_wr_pend <= 1'b1;
         end
      end
   end

   assign bus.readdata      = r_readdata;
   assign bus.waitrequest   = (bus.read | bus.write) & ~w_done;
   assign bus.MonDReg       = r_mon_d;
   assign bus.monitor_ready = r_ready;
   assign bus.monitor_error = r_error;
endmodule

// File: tb/tb_nios_system_tec2_cpu_cpu_ocimem_ctrl.sv
// tb_nios_system_tec2_cpu_cpu_ocimem_ctrl: random + directed JTAG/CPU traffic against a word-array model,
// with a queue scoreboard popped by a monitor on monitor_ready rising and on CPU read completion.
module tb_nios_system_tec2_cpu_cpu_ocimem_ctrl;
`ifdef OCIMEM_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   nios_system_tec2_cpu_cpu_ocimem_ctrl_if bus();
   nios_system_tec2_cpu_cpu_ocimem_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_mem [256];
   int          m_a;
   logic [31:0] m_md;
   logic        m_err;
   logic [32:0] q_jtag [$];
   logic [31:0] q_cpu [$];
   logic [32:0] m_e;
   logic        prev_ready = 1'b0;
   logic        cpu_pend = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_ready = 1'b0;
         cpu_pend   = 1'b0;
      end else begin
         if (cpu_pend) begin
            cpu_pend = 1'b0;
            if (q_cpu.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cpu_unexpected: readdata %h with nothing expected", bus.readdata);
            end else chk("cpu_readdata", bus.readdata, q_cpu.pop_front());
         end
         if (bus.read && !bus.waitrequest) cpu_pend = 1'b1;
         if (bus.monitor_ready && !prev_ready) begin
            if (q_jtag.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL jtag_unexpected: monitor_ready rose with MonDReg %h, nothing expected", bus.MonDReg);
            end else begin
               m_e = q_jtag.pop_front();
               chk("jtag_MonDReg", bus.MonDReg, m_e[31:0]);
               chk("jtag_error", 32'(bus.monitor_error), 32'(m_e[32]));
            end
         end
         prev_ready = bus.monitor_ready;
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input int which);
      bus.take_action_ocimem_a    = (which == 0);
      bus.take_no_action_ocimem_a = (which == 1);
      bus.take_action_ocimem_b    = (which == 2);
      @(posedge clk);
      #1;
      bus.take_action_ocimem_a    = 1'b0;
      bus.take_no_action_ocimem_a = 1'b0;
      bus.take_action_ocimem_b    = 1'b0;
   endtask

   task automatic expect_jtag();
      if (m_a < 256) m_md = m_mem[m_a];
      else m_err = 1'b1;
      q_jtag.push_back({m_err, m_md});
   endtask

   task automatic wait_ready(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = bus.monitor_ready;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: monitor_ready got 0 expected 1 within 40 cycles", name);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input string name, output int waits);
      bit ok = 1'b0;
      waits = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.waitrequest) waits++;
         else ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: waitrequest got 1 expected 0 within 40 cycles", name);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic jtag_load(input int a, input bit rd);
      bus.jdo        = '0;
      bus.jdo[34:26] = a[8:0];
      bus.jdo[17]    = rd;
      m_a   = a;
      m_err = 1'b0;
      if (rd) expect_jtag();
      strobe(0);
      if (rd) wait_ready("jtag_load_rd");
   endtask

   task automatic jtag_write(input logic [31:0] d);
      bus.jdo       = '0;
      bus.jdo[34:3] = d;
      m_md = d;
      if (m_a < 256) m_mem[m_a] = d;
      else m_err = 1'b1;
      if (AUTOINC) m_a = (m_a + 1) % 512;
      strobe(2);
      idle_cycles(2);
   endtask

   task automatic jtag_next();
      if (AUTOINC) m_a = (m_a + 1) % 512;
      expect_jtag();
      strobe(1);
      wait_ready("jtag_next");
   endtask

   task automatic b2b(input int gap);
      if (AUTOINC) m_a = (m_a + 1) % 512;
      strobe(1);
      idle_cycles(gap);
      if (AUTOINC) m_a = (m_a + 1) % 512;
      expect_jtag();
      strobe(1);
      wait_ready("b2b_next");
   endtask

   task automatic cpu_write(input int a, input logic [31:0] d, input logic [3:0] be);
      int w;
      for (int b = 0; b < 4; b++)
         if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
      bus.address    = a[7:0];
      bus.writedata  = d;
      bus.byteenable = be;
      bus.write      = 1'b1;
      wait_accept("cpu_write", w);
      bus.write = 1'b0;
   endtask

   task automatic cpu_read(input int a, input int exp_w);
      int w;
      q_cpu.push_back(m_mem[a]);
      bus.address = a[7:0];
      bus.read    = 1'b1;
      wait_accept("cpu_read", w);
      bus.read = 1'b0;
      if (exp_w >= 0) chk("cpu_read_waits", 32'(w), 32'(exp_w));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int op, a;
      bus.jdo                     = '0;
      bus.take_action_ocimem_a    = 1'b0;
      bus.take_no_action_ocimem_a = 1'b0;
      bus.take_action_ocimem_b    = 1'b0;
      bus.address                 = '0;
      bus.read                    = 1'b0;
      bus.write                   = 1'b0;
      bus.writedata               = '0;
      bus.byteenable              = '0;
      m_a   = 0;
      m_md  = '0;
      m_err = 1'b0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_MonDReg", bus.MonDReg, 32'h0);
      chk("rst_ready", 32'(bus.monitor_ready), 32'h0);
      chk("rst_error", 32'(bus.monitor_error), 32'h0);
      chk("rst_readdata", bus.readdata, 32'h0);
      chk("rst_waitrequest", 32'(bus.waitrequest), 32'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 256; i++) cpu_write(i, $urandom, 4'hf);
      // JTAG read latency: strobe in cycle N, result visible in N+3
      jtag_load(16, 1'b0);
      jtag_write(32'hCAFEF00D);
      bus.jdo        = '0;
      bus.jdo[34:26] = 9'h010;
      bus.jdo[17]    = 1'b1;
      m_a   = 16;
      m_err = 1'b0;
      expect_jtag();
      strobe(0);
      @(negedge clk);
      chk("lat_ready_n1", 32'(bus.monitor_ready), 32'h0);
      @(negedge clk);
      chk("lat_ready_n2", 32'(bus.monitor_ready), 32'h0);
      @(negedge clk);
      chk("lat_ready_n3", 32'(bus.monitor_ready), 32'h1);
      chk("lat_MonDReg", bus.MonDReg, 32'hCAFEF00D);
      idle_cycles(1);
      cpu_read(16, 1);
      // writes crossing the top of the RAM
      jtag_load(9'h0FE, 1'b0);
      jtag_write(32'hAAAA0001);
      jtag_write(32'hBBBB0002);
      jtag_write(32'hCCCC0003);
      chk("oor_write_error", 32'(bus.monitor_error), AUTOINC ? 32'h1 : 32'h0);
      cpu_read(254, 1);
      cpu_read(255, 1);
      cpu_read(0, 1);
      jtag_next();
      // byte lanes
      cpu_write(5, 32'hFFFFFFFF, 4'hf);
      cpu_write(5, 32'h12345678, 4'b0011);
      q_cpu.push_back(32'hFFFF5678);
      void'(q_cpu.pop_back());
      cpu_read(5, 1);
      // CPU read stalled behind a pending JTAG read
      bus.jdo        = '0;
      bus.jdo[34:26] = 9'h020;
      bus.jdo[17]    = 1'b1;
      m_a   = 32;
      m_err = 1'b0;
      expect_jtag();
      strobe(0);
      cpu_read(48, 3);
      idle_cycles(2);
      // back-to-back read-next strobes
      jtag_load(64, 1'b0);
      b2b(0);
      b2b(1);
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: begin
               a = ($urandom_range(0, 7) == 0) ? $urandom_range(256, 511) : $urandom_range(0, 255);
               jtag_load(a, 1'($urandom_range(0, 1)));
            end
            1: jtag_write($urandom);
            2: jtag_next();
            3, 4: cpu_write($urandom_range(0, 255), $urandom, 4'($urandom_range(0, 15)));
            default: cpu_read($urandom_range(0, 255), 1);
         endcase
      end
      // reset in the middle of JTAG_RD
      bus.jdo        = '0;
      bus.jdo[34:26] = 9'h010;
      bus.jdo[17]    = 1'b1;
      cpu_write(16, 32'h5A5AA5A5, 4'hf);
      jtag_load(16, 1'b1);
      bus.jdo[34:26] = 9'h011;
      strobe(0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(bus.monitor_ready), 32'h0);
      chk("midrst_MonDReg", bus.MonDReg, 32'h0);
      chk("midrst_error", 32'(bus.monitor_error), 32'h0);
      idle_cycles(2);
      @(negedge clk);
      reset_n = 1'b1;
      m_a   = 0;
      m_md  = '0;
      m_err = 1'b0;
      idle_cycles(1);
      cpu_read(16, 1);
      jtag_load(16, 1'b1);
      idle_cycles(4);
      chk("jtag_queue_empty", 32'(q_jtag.size()), 32'h0);
      chk("cpu_queue_empty", 32'(q_cpu.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
